// File: rtl/vfilter_ctrl.sv
// vfilter_ctrl: 3-tap vertical filter request sequencer.
// Issues cache reads, filters kept rows, writes results back.
module vfilter_ctrl #(
  parameter int WIDTH     = 352,
  parameter int HEIGHT    = 288,
  parameter int READ_LAT  = 2,
  parameter int RES_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        en,
  output logic        we,
  output logic [31:0] di,
  input  logic        row_cached,
  input  logic [31:0] doa,
  input  logic [31:0] dob,
  input  logic [31:0] doc
);

  localparam int RW     = WIDTH / 4;
  localparam int NREAD  = HEIGHT * RW;
  localparam int NWRITE = (HEIGHT - 2) * RW;
  localparam int CW     = $clog2(NREAD + 1);
  localparam int PW     = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int OW     = $clog2(RES_DEPTH + 1);
  localparam int LW     = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
  logic                err_q, err_d;
  logic [READ_LAT-1:0] vld_q, vld_d;
  logic [READ_LAT-1:0] keep_q, keep_d;
  logic [31:0]         mem_q [RES_DEPTH];
  logic [31:0]         mem_d [RES_DEPTH];
  logic [PW-1:0]       wp_q, wp_d;
  logic [PW-1:0]       rp_q, rp_d;
  logic [OW-1:0]       occ_q, occ_d;

  logic [LW-1:0] infl;
  logic          do_wr;
  logic          do_rd;
  logic          push;
  logic          accept;
  logic [9:0]    sum;
  logic [31:0]   res;

  assign busy   = (state_q == RUN) || (state_q == DRAIN);
  assign done   = (state_q == DONE);
  assign err    = err_q;
  assign push   = vld_q[READ_LAT-1] && keep_q[READ_LAT-1];
  assign accept = (state_q == IDLE) && start;

  // Request arbitration: drain results first, read only with buffer room
  always_comb begin
    infl = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      infl = infl + LW'(vld_q[i]);
    end
    do_wr = busy && (occ_q != '0);
    do_rd = !do_wr && (state_q == RUN) &&
            (int'(occ_q) + int'(infl) < RES_DEPTH);
    en = do_wr || do_rd;
    we = do_wr;
    di = do_wr ? mem_q[rp_q] : '0;
  end

  // Per-lane (a + 2b + c) >> 2 with no carry across lanes
  always_comb begin
    sum = '0;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      sum = {2'b00, doa[8*i +: 8]} +
            {1'b0, dob[8*i +: 8], 1'b0} +
            {2'b00, doc[8*i +: 8]};
      res[8*i +: 8] = 8'(sum >> 2);
    end
  end

  // Next state, counters, read pipeline and result buffer
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    vld_d    = '0;
    keep_d   = '0;
    mem_d    = mem_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    occ_d    = occ_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (do_rd && rd_cnt_q == CW'(NREAD - 1))
                 state_d = DRAIN;
      DRAIN:   if (do_wr && wr_cnt_q == CW'(NWRITE - 1))
                 state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      err_d    = 1'b0;
    end
    if (do_rd) begin
      rd_cnt_d = rd_cnt_q + CW'(1);
      if (rd_cnt_q >= CW'(RW) && !row_cached) err_d = 1'b1;
    end
    if (do_wr) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
      rp_d     = rp_q + PW'(1);
    end
    vld_d[0]  = do_rd;
    keep_d[0] = do_rd && (rd_cnt_q >= CW'(2 * RW));
    for (int i = 1; i < READ_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      keep_d[i] = keep_q[i-1];
    end
    if (push) begin
      mem_d[wp_q] = res;
      wp_d        = wp_q + PW'(1);
    end
    occ_d = occ_q + OW'(push) - OW'(do_wr);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
      vld_q    <= '0;
      keep_q   <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      occ_q    <= '0;
      for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      keep_q   <= keep_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      occ_q    <= occ_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_vfilter_ctrl.sv
// tb_vfilter_ctrl: randomized bench with a data-level reference
// model of the filter, request counts, err and done behaviour.
module tb_vfilter_ctrl;

  localparam int W   = 16;
  localparam int H   = 6;
  localparam int LAT = 2;
  localparam int DEP = 4;
  localparam int RW     = W / 4;
  localparam int NREAD  = H * RW;
  localparam int NWRITE = (H - 2) * RW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, err, en, we;
  logic [31:0] di;
  logic        row_cached;
  logic [31:0] doa, dob, doc;

  vfilter_ctrl #(
    .WIDTH(W), .HEIGHT(H), .READ_LAT(LAT), .RES_DEPTH(DEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .err(err),
    .en(en), .we(we), .di(di),
    .row_cached(row_cached),
    .doa(doa), .dob(dob), .doc(doc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int rd_k = 0;
  int wr_n = 0;
  int done_cnt = 0;
  bit err_m = 1'b0;
  int dmode = 0;
  int rcm = 0;
  logic [31:0] exp_q[$];
  logic [31:0] dla [LAT+1];
  logic [31:0] dlb [LAT+1];
  logic [31:0] dlc [LAT+1];
  logic [31:0] ga, gb, gc, w;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] filt(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = int'(a[8*i +: 8]) + 2 * int'(b[8*i +: 8]) + int'(c[8*i +: 8]);
      r[8*i +: 8] = 8'(s / 4);
    end
    return r;
  endfunction

  // Observe requests mid-cycle, feed delayed cache data, track model
  always @(negedge clk) begin
    if (!rst_n) begin
      err_m = 1'b0;
      exp_q.delete();
    end else begin
      chk("err", {31'd0, err}, {31'd0, err_m});
      if (!busy) chk("idle_en", {31'd0, en}, 32'd0);
      if (done) done_cnt++;
      if (en && we) begin
        wr_n++;
        if (exp_q.size() == 0) chk("wr_unexpected", exp_q.size(), 1);
        else begin
          w = exp_q.pop_front();
          chk("di", di, w);
        end
      end
      case (rcm)
        0:       row_cached = 1'b1;
        1:       row_cached = 1'b0;
        default: row_cached = 1'($urandom_range(0, 1));
      endcase
      case (dmode)
        1: begin ga = 32'h80808080; gb = 32'h80808080; gc = 32'h80808080; end
        2: begin ga = 32'hFFFFFFFF; gb = 32'h00000000; gc = 32'hFFFFFFFF; end
        3: begin ga = 32'h01FF0010; gb = 32'h03FF0020; gc = 32'h05FF0030; end
        default: begin ga = $urandom; gb = $urandom; gc = $urandom; end
      endcase
      for (int i = LAT; i > 0; i--) begin
        dla[i] = dla[i-1];
        dlb[i] = dlb[i-1];
        dlc[i] = dlc[i-1];
      end
      dla[0] = ga;
      dlb[0] = gb;
      dlc[0] = gc;
      doa = dla[LAT];
      dob = dlb[LAT];
      doc = dlc[LAT];
      if (en && !we) begin
        if (rd_k >= RW && !row_cached) err_m = 1'b1;
        if (rd_k >= 2 * RW) exp_q.push_back(filt(ga, gb, gc));
        rd_k++;
      end
      if (start && !busy && !done) begin
        err_m = 1'b0;
        rd_k = 0;
        wr_n = 0;
        done_cnt = 0;
        exp_q.delete();
      end
    end
  end

  task automatic start_pulse();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_pass(input bit ign, input int xe);
    bit p1, p2;
    int cyc;
    p1 = 1'b0;
    p2 = 1'b0;
    cyc = 0;
    start_pulse();
    chk("busy_start", {31'd0, busy}, 32'd1);
    chk("err_clr", {31'd0, err}, 32'd0);
    while (done_cnt == 0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (ign && !p1 && rd_k >= 3 && rd_k < NREAD) begin
        start = 1'b1;
        p1 = 1'b1;
      end else if (ign && p1 && !p2 && rd_k == NREAD) begin
        start = 1'b1;
        p2 = 1'b1;
      end
    end
    start = 1'b0;
    if (done_cnt == 0) chk("timeout", done_cnt, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_cnt", done_cnt, 1);
    chk("reads", rd_k, NREAD);
    chk("writes", wr_n, NWRITE);
    chk("leftover", exp_q.size(), 0);
    chk("busy_end", {31'd0, busy}, 32'd0);
    if (xe < 0) chk("err_end", {31'd0, err}, {31'd0, err_m});
    else chk("err_end", {31'd0, err}, xe);
  endtask

  initial begin
    int cyc;
    int snap;
    rst_n = 1'b0;
    start = 1'b0;
    row_cached = 1'b1;
    doa = '0;
    dob = '0;
    doc = '0;
    for (int i = 0; i <= LAT; i++) begin
      dla[i] = '0;
      dlb[i] = '0;
      dlc[i] = '0;
    end
    #12;
    chk("rst_en", {31'd0, en}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_di", di, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    dmode = 1; rcm = 0; run_pass(1'b0, 0);
    dmode = 2; rcm = 0; run_pass(1'b0, 0);
    dmode = 3; rcm = 0; run_pass(1'b0, 0);
    dmode = 0; rcm = 2; run_pass(1'b0, -1);
    dmode = 0; rcm = 2; run_pass(1'b0, -1);

    dmode = 0; rcm = 1; run_pass(1'b0, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", {31'd0, err}, 32'd1);
    rcm = 0; run_pass(1'b0, 0);

    dmode = 0; rcm = 0; run_pass(1'b1, 0);

    dmode = 0; rcm = 0;
    start_pulse();
    cyc = 0;
    while (wr_n < 5 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (wr_n < 5) chk("timeout_wr5", wr_n, 5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", {31'd0, en}, 32'd0);
    chk("mid_rst_we", {31'd0, we}, 32'd0);
    chk("mid_rst_di", di, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    snap = rd_k + wr_n;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_req", rd_k + wr_n, snap);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    run_pass(1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
